// File: rtl/dcache_sa_controller.sv
// dcache_sa_controller
// Write-back, write-allocate data cache controller (1- or 2-way, true LRU)
// between the MEM pipeline stage and a line-wide data memory. A miss stalls
// the pipeline through an optional dirty-victim write-back and a line refill;
// the still-present CPU request is then replayed as a hit.
//
// Ports:
//   clk_i, rst_i                 clock (rising edge), async active-low reset
//   mem_data_i, mem_ack_i        refill line and one-cycle completion pulse
//   mem_data_o, mem_addr_o       victim line / line-aligned request address
//   mem_enable_o, mem_write_o    request valid (held until ack), 1 = write-back
//   cpu_data_i, cpu_addr_i       store data, byte address ([1:0] ignored)
//   cpu_MemRead_i/MemWrite_i     load / store request (both high = store)
//   cpu_data_o, cpu_stall_o      load data, pipeline freeze
module dcache_sa_controller #(
  parameter int SETS      = 16,
  parameter int LINE_BITS = 256,
  parameter int WAYS      = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [LINE_BITS-1:0] mem_data_i,
  input  logic                 mem_ack_i,
  output logic [LINE_BITS-1:0] mem_data_o,
  output logic [31:0]          mem_addr_o,
  output logic                 mem_enable_o,
  output logic                 mem_write_o,
  input  logic [31:0]          cpu_data_i,
  input  logic [31:0]          cpu_addr_i,
  input  logic                 cpu_MemRead_i,
  input  logic                 cpu_MemWrite_i,
  output logic [31:0]          cpu_data_o,
  output logic                 cpu_stall_o
);
  localparam int IDX  = $clog2(SETS);
  localparam int OFF  = $clog2(LINE_BITS / 8);
  localparam int TAG  = 32 - IDX - OFF;
  localparam int WSEL = OFF - 2;
  localparam int BPOS = $clog2(LINE_BITS);

  if (WAYS != 1 && WAYS != 2) begin : g_bad_ways
    $error("dcache_sa_controller: WAYS must be 1 or 2");
  end

  typedef enum logic [1:0] {S_IDLE, S_WRITEBACK, S_REFILL} state_t;

  // Storage always has two way slots; with WAYS=1 way 1 is never hit or
  // chosen as victim, so it is dead logic that synthesis removes.
  logic [TAG-1:0]       r_tag  [2][SETS];
  logic [LINE_BITS-1:0] r_data [2][SETS];
  logic [SETS-1:0][1:0] r_valid;
  logic [SETS-1:0][1:0] r_dirty;
  logic [SETS-1:0]      r_lru;      // names the least-recently-used way
  logic                 r_victim;   // way being replaced during a miss
  state_t               r_state;
  state_t               w_next;

  logic [TAG-1:0]       w_tag;
  logic [IDX-1:0]       w_idx;
  logic [WSEL-1:0]      w_word;
  logic [BPOS-1:0]      w_bitpos;
  logic                 w_req;
  logic [1:0]           w_hit_vec;
  logic                 w_hit;
  logic                 w_hit_way;
  logic                 w_victim;
  logic                 w_idle_hit;
  logic                 w_idle_miss;
  logic                 w_refill_done;
  logic [LINE_BITS-1:0] w_hit_line;
  logic [1:0]           w_unused_addr;

  assign w_tag         = cpu_addr_i[31 -: TAG];
  assign w_idx         = cpu_addr_i[OFF +: IDX];
  assign w_word        = cpu_addr_i[2 +: WSEL];
  assign w_bitpos      = {w_word, 5'b00000};
  assign w_unused_addr = cpu_addr_i[1:0];
  assign w_req         = cpu_MemRead_i | cpu_MemWrite_i;

  assign w_hit_vec[0] = r_valid[w_idx][0] && (r_tag[0][w_idx] == w_tag);
  assign w_hit_vec[1] = (WAYS == 2) && r_valid[w_idx][1] && (r_tag[1][w_idx] == w_tag);
  assign w_hit        = |w_hit_vec;
  assign w_hit_way    = w_hit_vec[1];
  assign w_hit_line   = r_data[w_hit_way][w_idx];

  assign w_idle_hit    = (r_state == S_IDLE) && w_req && w_hit;
  assign w_idle_miss   = (r_state == S_IDLE) && w_req && !w_hit;
  assign w_refill_done = (r_state == S_REFILL) && mem_ack_i;

  // Victim choice: first invalid way (way 0 preferred), else the LRU way.
  always_comb begin
    w_victim = 1'b0;
    if (!r_valid[w_idx][0]) begin
      w_victim = 1'b0;
    end else if (WAYS == 2) begin
      w_victim = r_valid[w_idx][1] ? r_lru[w_idx] : 1'b1;
    end else begin
      w_victim = 1'b0;
    end
  end

  // FSM state register.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // FSM next state and memory-port outputs; all outputs derive from
  // registered state and the held CPU address, so they stay stable until ack.
  always_comb begin
    w_next       = r_state;
    mem_enable_o = 1'b0;
    mem_write_o  = 1'b0;
    mem_addr_o   = 32'h0000_0000;
    mem_data_o   = '0;
    case (r_state)
      S_IDLE: begin
        if (w_idle_miss) begin
          if (r_valid[w_idx][w_victim] && r_dirty[w_idx][w_victim]) begin
            w_next = S_WRITEBACK;
          end else begin
            w_next = S_REFILL;
          end
        end else begin
          w_next = S_IDLE;
        end
      end
      S_WRITEBACK: begin
        mem_enable_o = 1'b1;
        mem_write_o  = 1'b1;
        mem_addr_o   = {r_tag[r_victim][w_idx], w_idx, {OFF{1'b0}}};
        mem_data_o   = r_data[r_victim][w_idx];
        if (mem_ack_i) begin
          w_next = S_REFILL;
        end else begin
          w_next = S_WRITEBACK;
        end
      end
      S_REFILL: begin
        mem_enable_o = 1'b1;
        mem_addr_o   = {w_tag, w_idx, {OFF{1'b0}}};
        if (mem_ack_i) begin
          w_next = S_IDLE;
        end else begin
          w_next = S_REFILL;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Valid/dirty/LRU bookkeeping; the refill leaves LRU alone because the
  // replay hit on the following cycle updates it.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_valid  <= '0;
      r_dirty  <= '0;
      r_lru    <= '0;
      r_victim <= 1'b0;
    end else begin
      if (w_idle_hit) begin
        r_lru[w_idx] <= ~w_hit_way;
        if (cpu_MemWrite_i) begin
          r_dirty[w_idx][w_hit_way] <= 1'b1;
        end
      end
      if (w_idle_miss) begin
        r_victim <= w_victim;
      end
      if (w_refill_done) begin
        r_valid[w_idx][r_victim] <= 1'b1;
        r_dirty[w_idx][r_victim] <= 1'b0;
      end
    end
  end

  // Tag and line arrays: store-hit word write and refill line write.
  always_ff @(posedge clk_i) begin
    if (rst_i && w_idle_hit && cpu_MemWrite_i) begin
      r_data[w_hit_way][w_idx][w_bitpos +: 32] <= cpu_data_i;
    end
    if (rst_i && w_refill_done) begin
      r_data[r_victim][w_idx] <= mem_data_i;
      r_tag[r_victim][w_idx]  <= w_tag;
    end
  end

  // Load data: only a read hit in IDLE returns data; a combined read/write is a store.
  always_comb begin
    cpu_data_o = 32'h0000_0000;
    if (rst_i && w_idle_hit && cpu_MemRead_i && !cpu_MemWrite_i) begin
      cpu_data_o = w_hit_line[w_bitpos +: 32];
    end else begin
      cpu_data_o = 32'h0000_0000;
    end
  end

  assign cpu_stall_o = rst_i & ((r_state != S_IDLE) | (w_req & ~w_hit));

endmodule
